an_decoder: RTL

- GTIA-side receiver for the ANTIC AN[2:0] output bus; the consuming end of the code stream ANTIC drives every color clock.
- Registers and decodes each AN code into a pixel class, hires pixel pair and blank/sync flags.
- Recovers horizontal/vertical beam position and frame count from blank/sync codes; flags malformed timing.
- Feeds the GTIA color/priority logic.

---
 rtl/an_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/an_decoder.sv
// GTIA-side receiver for the ANTIC AN[2:0] code bus: registered pixel-class
// decode plus beam position, frame tracking and timing-error detection.
module an_decoder #(
  parameter int unsigned LINE_CLOCKS = 228,
  parameter int unsigned FRAME_LINES = 262,
  parameter int unsigned VSYNC_MIN   = 3
) (
  input  logic       phi2,
  input  logic       RST,
  input  logic [2:0] AN,
  input  logic       hires,
  output logic [2:0] pf_class,
  output logic [1:0] hires_pix,
  output logic       hires_valid,
  output logic       hblank,
  output logic       vsync,
  output logic [7:0] hpos,
  output logic [8:0] vpos,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {SEARCH, VSYNC, ACTIVE} state_t;

  state_t      r_state, w_state_nx;
  logic        r_prev_blank;
  logic [7:0]  r_vs_lines, w_vs_lines_nx;
  logic [2:0]  r_pf;
  logic [1:0]  r_hpix;
  logic        r_hval, r_hblank, r_vsync, r_fs, r_locked, r_err;
  logic [7:0]  r_hpos, w_hpos_nx, r_fcnt, w_fcnt_nx;
  logic [8:0]  r_vpos, w_vpos_nx;
  logic        w_fs_nx, w_locked_nx, w_err_nx;
  logic [2:0]  w_pf;
  logic [1:0]  w_hpix;
  logic        w_hval, w_is_blank, w_is_vs, w_hb_edge;

  assign w_is_blank = (AN[2:1] == 2'b01);
  assign w_is_vs    = (AN == 3'b001) || (AN == 3'b011);
  assign w_hb_edge  = w_is_blank && !r_prev_blank;

  always_comb begin
    w_pf   = 3'b000;
    w_hpix = '0;
    w_hval = 1'b0;
    if (AN[2]) begin
      if (hires) begin
        w_pf   = 3'b110;
        w_hpix = AN[1:0];
        w_hval = 1'b1;
      end else begin
        w_pf = {1'b1, AN[1:0]};
      end
    end else if (AN[1]) begin
      w_pf = 3'b011;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_hpos_nx     = r_hpos;
    w_vpos_nx     = r_vpos;
    w_vs_lines_nx = r_vs_lines;
    w_fs_nx       = 1'b0;
    w_fcnt_nx     = r_fcnt;
    w_locked_nx   = r_locked;
    w_err_nx      = r_err;
    unique case (r_state)
      SEARCH: begin
        w_hpos_nx = '0;
        w_vpos_nx = '0;
        if (w_is_vs) begin
          w_state_nx    = VSYNC;
          w_vs_lines_nx = '0;
        end
      end
      VSYNC: begin
        if (!w_is_vs) begin
          w_hpos_nx = '0;
          w_vpos_nx = '0;
          if (r_vs_lines >= 8'(VSYNC_MIN)) begin
            w_state_nx  = ACTIVE;
            w_fs_nx     = 1'b1;
            w_fcnt_nx   = r_fcnt + 8'd1;
            w_locked_nx = 1'b1;
          end else begin
            w_state_nx = SEARCH;
            w_err_nx   = 1'b1;
          end
        end else if (w_hb_edge && (r_vs_lines != '1)) begin
          w_vs_lines_nx = r_vs_lines + 8'd1;
        end
      end
      ACTIVE: begin
        if (w_hb_edge) begin
          w_hpos_nx = '0;
          if (r_vpos == 9'(FRAME_LINES - 1)) w_err_nx  = 1'b1;
          else                               w_vpos_nx = r_vpos + 9'd1;
        end else if (r_hpos == 8'(LINE_CLOCKS - 1)) begin
          w_err_nx = 1'b1;
        end else begin
          w_hpos_nx = r_hpos + 8'd1;
        end
        // A 011 that is also an hblank edge closes this line and opens vsync
        // with that line already counted.
        if (w_is_vs) begin
          w_state_nx    = VSYNC;
          w_vs_lines_nx = w_hb_edge ? 8'd1 : 8'd0;
        end
      end
      default: w_state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (RST) begin
      r_state      <= SEARCH;
      r_prev_blank <= 1'b0;
      r_vs_lines   <= '0;
      r_pf         <= 3'b011;
      r_hpix       <= '0;
      r_hval       <= 1'b0;
      r_hblank     <= 1'b0;
      r_vsync      <= 1'b0;
      r_hpos       <= '0;
      r_vpos       <= '0;
      r_fs         <= 1'b0;
      r_fcnt       <= '0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_prev_blank <= w_is_blank;
      r_vs_lines   <= w_vs_lines_nx;
      r_pf         <= w_pf;
      r_hpix       <= w_hpix;
      r_hval       <= w_hval;
      r_hblank     <= w_is_blank;
      r_vsync      <= (w_state_nx == VSYNC);
      r_hpos       <= w_hpos_nx;
      r_vpos       <= w_vpos_nx;
      r_fs         <= w_fs_nx;
      r_fcnt       <= w_fcnt_nx;
      r_locked     <= w_locked_nx;
      r_err        <= w_err_nx;
    end
  end

  assign pf_class    = r_pf;
  assign hires_pix   = r_hpix;
  assign hires_valid = r_hval;
  assign hblank      = r_hblank;
  assign vsync       = r_vsync;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign frame_start = r_fs;
  assign frame_cnt   = r_fcnt;
  assign locked      = r_locked;
  assign sync_err    = r_err;

endmodule
